// File: rtl/sym_pkg.sv
// Shared types and constants for the symbol game controller slice.
// Holds the round FSM encoding, blank display code and timer width.
package sym_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int TMR_W = 32;
    localparam logic [7:0] SYM_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        DRAIN  = 3'd2,
        GUESS  = 3'd3,
        RESULT = 3'd4
    } state_t;

    // A zero-length play window still runs for one cycle.
    function automatic logic [TMR_W-1:0] play_len(input logic [TMR_W-1:0] cycles);
        return (cycles == '0) ? TMR_W'(1) : cycles;
    endfunction

endpackage

// File: rtl/sym_game_ctrl_if.sv
// Bundle between the game controller and its environment: round control,
// upstream symbol stream, player guess and the display/result outputs.
interface sym_game_ctrl_if import sym_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);

    logic             start;
    logic [TMR_W-1:0] gameCycles;
    logic             generated;
    logic             special;
    logic [7:0]       generatedSym;
    logic             guessValid;
    logic [CNT_W-1:0] guess;

    logic             genSym;
    logic [7:0]       displaySym;
    logic [CNT_W-1:0] symCount;
    logic [CNT_W-1:0] specialCount;
    logic [2:0]       state;
    logic             resultValid;
    logic             win;

    // Environment side: symbol source, player input, display.
    modport master (
        output start, gameCycles, generated, special, generatedSym,
        output guessValid, guess,
        input  genSym, displaySym, symCount, specialCount, state,
        input  resultValid, win
    );

    // Controller side.
    modport slave (
        input  start, gameCycles, generated, special, generatedSym,
        input  guessValid, guess,
        output genSym, displaySym, symCount, specialCount, state,
        output resultValid, win
    );

endinterface

// File: rtl/sym_timer.sv
// Loadable 32-bit down-counter; stops at zero. Flags the last count (==1)
// and expiry (==0) so the caller can leave a state exactly on time.
module sym_timer import sym_pkg::*; (
    input  logic             Clk100M,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             last,
    output logic             expired
);

    logic [TMR_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk100M or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && !expired) begin
            count_q <= count_q - TMR_W'(1);
        end
    end

    assign expired = (count_q == '0);
    assign last    = (count_q == TMR_W'(1));

endmodule

// File: rtl/sym_game_ctrl.sv
// Round controller: opens a play window for the symbol generator, tallies
// accepted and special symbols, then scores the player's guess.
module sym_game_ctrl import sym_pkg::*; #(
    parameter int          CNT_W         = CNT_W_DEF,
    parameter logic [31:0] GUESS_TIMEOUT = 32'd1_000_000_000
) (
    input  logic           Clk100M,
    input  logic           rst,
    sym_game_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             play_load, guess_load, round_clear;
    logic             win_load, win_d;
    logic             accept;
    logic             play_last, play_expired;
    logic             guess_last, guess_expired;
    logic [CNT_W-1:0] sym_cnt_q, spec_cnt_q;
    logic [7:0]       disp_q;
    logic             win_q;

    sym_timer u_play_timer (
        .Clk100M  (Clk100M),
        .rst      (rst),
        .load     (play_load),
        .load_val (play_len(bus.gameCycles)),
        .en       (state_q == PLAY),
        .last     (play_last),
        .expired  (play_expired)
    );

    sym_timer u_guess_timer (
        .Clk100M  (Clk100M),
        .rst      (rst),
        .load     (guess_load),
        .load_val (GUESS_TIMEOUT),
        .en       (state_q == GUESS),
        .last     (guess_last),
        .expired  (guess_expired)
    );

    always_ff @(posedge Clk100M or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value held and infer a latch.
    always_comb begin
        state_d     = state_q;
        play_load   = 1'b0;
        guess_load  = 1'b0;
        round_clear = 1'b0;
        win_load    = 1'b0;
        win_d       = win_q;
        case (state_q)
            IDLE, RESULT: begin
                if (bus.start) begin
                    round_clear = 1'b1;
                    play_load   = 1'b1;
                    state_d     = PLAY;
                end
            end
            PLAY: begin
                if (play_last || play_expired) state_d = DRAIN;
            end
            DRAIN: begin
                guess_load = 1'b1;
                state_d    = GUESS;
            end
            GUESS: begin
                // A guess arriving on the expiry cycle still gets scored.
                if (bus.guessValid) begin
                    win_load = 1'b1;
                    win_d    = (bus.guess == spec_cnt_q);
                    state_d  = RESULT;
                end else if (GUESS_TIMEOUT != '0 && (guess_last || guess_expired)) begin
                    win_load = 1'b1;
                    win_d    = 1'b0;
                    state_d  = RESULT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DRAIN still accepts: the generator's registered pulse lags genSym by one cycle.
    assign accept = bus.generated && (state_q == PLAY || state_q == DRAIN);

    always_ff @(posedge Clk100M or posedge rst) begin
        if (rst) begin
            sym_cnt_q  <= '0;
            spec_cnt_q <= '0;
            disp_q     <= SYM_BLANK;
            win_q      <= 1'b0;
        end else if (round_clear) begin
            sym_cnt_q  <= '0;
            spec_cnt_q <= '0;
            disp_q     <= SYM_BLANK;
            win_q      <= 1'b0;
        end else begin
            if (accept) begin
                disp_q <= bus.generatedSym;
                if (sym_cnt_q != CNT_MAX) sym_cnt_q <= sym_cnt_q + CNT_W'(1);
                if (bus.special && spec_cnt_q != CNT_MAX) spec_cnt_q <= spec_cnt_q + CNT_W'(1);
            end
            if (win_load) win_q <= win_d;
        end
    end

    assign bus.genSym       = (state_q == PLAY);
    assign bus.resultValid  = (state_q == RESULT);
    assign bus.state        = state_q;
    assign bus.displaySym   = disp_q;
    assign bus.symCount     = sym_cnt_q;
    assign bus.specialCount = spec_cnt_q;
    assign bus.win          = win_q;

endmodule
